// File: rtl/dmem_arb_pkg.sv
// Shared constants for the dmem arbiter: port ids and default bus widths.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

    // Index of each port's bit in the two-bit read-pending vector.
    localparam int RD_C = 0;
    localparam int RD_L = 1;

    function automatic logic other_port(input logic p);
        return (p == PORT_C) ? PORT_L : PORT_C;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the dmem-side signals.
// master: requesters and memory environment; slave: the arbiter.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] read_val;
    logic              REDMEM;
    logic [DATA_W-1:0] dmem_data;

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  dmem_addr, read_val, REDMEM,
        output dmem_data
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output dmem_addr, read_val, REDMEM,
        input  dmem_data
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant decision. A lone requester always wins; under
// contention the current owner keeps the port until it has taken
// MAX_BURST consecutive grants, then the other port gets it.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             c_req,
    input  logic             l_req,
    input  logic             owner,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             gnt_c,
    output logic             gnt_l
);

    logic winner;

    // Pick at most one port; c and l grants are mutually exclusive by construction.
    always_comb begin
        gnt_c  = 1'b0;
        gnt_l  = 1'b0;
        winner = owner;
        if (c_req && l_req) begin
            if (burst_cnt < CNT_W'(MAX_BURST)) begin
                winner = owner;
            end else begin
                winner = other_port(owner);
            end
            gnt_c = (winner == PORT_C);
            gnt_l = (winner == PORT_L);
        end else begin
            gnt_c = c_req;
            gnt_l = l_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port dmem between the CPU (C) and the loader (L).
// One access per cycle, grants are combinational, read data returns
// one cycle after the grant straight from the dmem registered output.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic           clk,
    input  logic           reset_arb,
    dmem_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             owner_q;
    logic             owner_d;
    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] burst_cnt_d;
    logic [1:0]       rd_pend_q;
    logic [1:0]       rd_pend_d;

    logic             gnt_c;
    logic             gnt_l;
    logic             gnt_any;
    logic             gnt_port;
    logic             c_rvalid;
    logic             l_rvalid;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .c_req     (bus.c_req),
        .l_req     (bus.l_req),
        .owner     (owner_q),
        .burst_cnt (burst_cnt_q),
        .gnt_c     (gnt_c),
        .gnt_l     (gnt_l)
    );

    assign gnt_any  = gnt_c | gnt_l;
    assign gnt_port = gnt_l ? PORT_L : PORT_C;

    // Burst bookkeeping: count consecutive grants to the owner, restart on a
    // hand-over, and clear on any idle cycle so a pause gives a fresh burst.
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (gnt_any) begin
            if (gnt_port == owner_q) begin
                if (burst_cnt_q != CNT_W'(MAX_BURST)) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end else begin
                owner_d     = gnt_port;
                burst_cnt_d = CNT_W'(1);
            end
        end else begin
            burst_cnt_d = '0;
        end
    end

    // Remember which port issued a read this cycle so its data can be steered back next cycle.
    always_comb begin
        rd_pend_d       = 2'b00;
        rd_pend_d[RD_C] = gnt_c & ~bus.c_we;
        rd_pend_d[RD_L] = gnt_l & ~bus.l_we;
    end

    // Drive dmem from the granted port; an idle cycle becomes a harmless read of address 0.
    always_comb begin
        bus.dmem_addr = '0;
        bus.read_val  = '0;
        bus.REDMEM    = 1'b0;
        if (gnt_c) begin
            bus.dmem_addr = bus.c_addr;
            bus.read_val  = bus.c_wdata;
            bus.REDMEM    = bus.c_we;
        end else if (gnt_l) begin
            bus.dmem_addr = bus.l_addr;
            bus.read_val  = bus.l_wdata;
            bus.REDMEM    = bus.l_we;
        end
    end

    // Arbitration state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_arb) begin
            owner_q     <= PORT_C;
            burst_cnt_q <= '0;
            rd_pend_q   <= 2'b00;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // A read issued just before reset must not surface while reset is held,
    // so the pending flags are masked by reset as well as cleared by it.
    assign c_rvalid = rd_pend_q[RD_C] & ~reset_arb;
    assign l_rvalid = rd_pend_q[RD_L] & ~reset_arb;

    assign bus.c_gnt    = gnt_c;
    assign bus.l_gnt    = gnt_l;
    assign bus.c_rvalid = c_rvalid;
    assign bus.l_rvalid = l_rvalid;
    assign bus.c_rdata  = c_rvalid ? bus.dmem_data : '0;
    assign bus.l_rdata  = l_rvalid ? bus.dmem_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256x8 registered-output dmem model.
module tb_dmem_arbiter;

    logic clk;
    logic reset_arb;
    logic init_mem;

    int   n_assert;
    int   n_fail;

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    logic       pend_c;
    logic       pend_l;
    logic [7:0] pend_cd;
    logic [7:0] pend_ld;
    logic [8:0] pat_c;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    dmem_arbiter #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .reset_arb (reset_arb),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // dmem: synchronous write, registered read output, 0 after a write.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            bus.dmem_data <= 8'h00;
        end else begin
            if (bus.REDMEM) mem[bus.dmem_addr] <= bus.read_val;
            bus.dmem_data <= bus.REDMEM ? 8'h00 : mem[bus.dmem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Check one cycle against expected grants and the bench's read-return model, then advance.
    task automatic step(input string tag, input logic ecg, input logic elg);
        logic erv_c;
        logic erv_l;
        #2;
        erv_c = pend_c & ~reset_arb;
        erv_l = pend_l & ~reset_arb;
        chk({tag, ".c_gnt"},    32'(bus.c_gnt),    32'(ecg));
        chk({tag, ".l_gnt"},    32'(bus.l_gnt),    32'(elg));
        chk({tag, ".c_rvalid"}, 32'(bus.c_rvalid), 32'(erv_c));
        chk({tag, ".l_rvalid"}, 32'(bus.l_rvalid), 32'(erv_l));
        chk({tag, ".c_rdata"},  32'(bus.c_rdata),  erv_c ? 32'(pend_cd) : 32'h0);
        chk({tag, ".l_rdata"},  32'(bus.l_rdata),  erv_l ? 32'(pend_ld) : 32'h0);
        chk({tag, ".REDMEM"},   32'(bus.REDMEM),   32'((ecg & bus.c_we) | (elg & bus.l_we)));
        if (ecg && bus.c_we) exp_mem[bus.c_addr] = bus.c_wdata;
        if (elg && bus.l_we) exp_mem[bus.l_addr] = bus.l_wdata;
        pend_cd = exp_mem[bus.c_addr];
        pend_ld = exp_mem[bus.l_addr];
        pend_c  = ecg & ~bus.c_we & ~reset_arb;
        pend_l  = elg & ~bus.l_we & ~reset_arb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        pend_c   = 1'b0;
        pend_l   = 1'b0;
        pend_cd  = 8'h00;
        pend_ld  = 8'h00;
        pat_c    = 9'b1_0000_1111;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;

        reset_arb   = 1'b1;
        init_mem    = 1'b1;
        bus.c_req   = 1'b1;
        bus.c_we    = 1'b0;
        bus.c_addr  = 8'h20;
        bus.c_wdata = 8'h00;
        bus.l_req   = 1'b1;
        bus.l_we    = 1'b0;
        bus.l_addr  = 8'h30;
        bus.l_wdata = 8'h00;

        // First reset cycle: state not yet cleared, only outputs masked by reset are defined.
        #2;
        chk("rst0.c_rvalid", 32'(bus.c_rvalid), 32'h0);
        chk("rst0.c_rdata",  32'(bus.c_rdata),  32'h0);
        chk("rst0.l_rvalid", 32'(bus.l_rvalid), 32'h0);
        chk("rst0.l_rdata",  32'(bus.l_rdata),  32'h0);
        @(posedge clk);
        #1;
        step("rst1", 1'b1, 1'b0);
        reset_arb = 1'b0;
        init_mem  = 1'b0;

        // Both read every cycle: C x4, L x4, then C again.
        for (int k = 0; k < 9; k++)
            step($sformatf("cont%0d", k), pat_c[k], ~pat_c[k]);

        // Loader alone for 10 cycles is never throttled.
        bus.c_req = 1'b0;
        for (int k = 0; k < 10; k++)
            step($sformatf("lone%0d", k), 1'b0, 1'b1);
        bus.c_req = 1'b1;
        step("c_arrive", 1'b1, 1'b0);

        // CPU write then read of 0x10.
        bus.l_req   = 1'b0;
        bus.c_we    = 1'b1;
        bus.c_addr  = 8'h10;
        bus.c_wdata = 8'hA5;
        step("wr", 1'b1, 1'b0);
        bus.c_we = 1'b0;
        step("rd", 1'b1, 1'b0);
        bus.c_req = 1'b0;
        step("rd_data", 1'b0, 1'b0);

        // Three CPU grants, an idle cycle, then contention gives CPU a full fresh burst.
        bus.c_req  = 1'b1;
        bus.c_addr = 8'h20;
        for (int k = 0; k < 3; k++)
            step($sformatf("pre%0d", k), 1'b1, 1'b0);
        bus.c_req = 1'b0;
        step("idle", 1'b0, 1'b0);
        bus.c_req = 1'b1;
        bus.l_req = 1'b1;
        for (int k = 0; k < 4; k++)
            step($sformatf("fresh%0d", k), 1'b1, 1'b0);
        step("fresh_l", 1'b0, 1'b1);

        // Read granted, then reset the following cycle: no rvalid may appear.
        bus.l_req  = 1'b0;
        bus.c_addr = 8'h44;
        step("rmid_rd", 1'b1, 1'b0);
        bus.c_req = 1'b0;
        reset_arb = 1'b1;
        step("rmid_rst", 1'b0, 1'b0);
        reset_arb = 1'b0;
        step("rmid_rel", 1'b0, 1'b0);
        bus.c_req = 1'b1;
        bus.l_req = 1'b1;
        step("post_rst", 1'b1, 1'b0);
        bus.c_req = 1'b0;
        bus.l_req = 1'b0;
        step("flush", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
